// File: rtl/mips_fetch_stage.sv
// Instruction-fetch stage: PC register, synchronous imem issue, 1-entry skid buffer, EX redirects.
// Optional `FETCH_PERF_EN adds saturating stall/redirect cycle counters.
module mips_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          IMEM_AW  = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall_i,
   input  logic               redirect_i,
   input  logic [31:0]        redirect_pc_i,
   output logic               imem_en_o,
   output logic [IMEM_AW-1:0] imem_addr_o,
   input  logic [31:0]        imem_rdata_i,
   output logic [31:0]        pc_out,
   output logic               id_valid_o,
   output logic [31:0]        id_instr_o,
   output logic [31:0]        id_pc_o,
   output logic [31:0]        id_pc4_o
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]        perf_stall_cnt_o,
   output logic [31:0]        perf_redirect_cnt_o
`endif
);

   logic [31:0] fetch_pc_r;
   logic        rsp_valid_r;
   logic [31:0] rsp_pc_r;
   logic        buf_valid_r;
   logic [31:0] buf_instr_r;
   logic [31:0] buf_pc_r;
   logic [31:0] redirect_target_s;

   // Word-align the redirect target; masking keeps the low bits referenced.
   assign redirect_target_s = redirect_pc_i & 32'hFFFF_FFFC;

   // Read strobe is held off while reset, stalled or redirecting.
   assign imem_en_o   = !rst && !stall_i && !redirect_i;
   assign imem_addr_o = fetch_pc_r[IMEM_AW+1:2];
   assign pc_out      = fetch_pc_r;

   // PC, in-flight response tracking, skid buffer and IF/ID register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_r  <= RESET_PC;
         rsp_valid_r <= 1'b0;
         rsp_pc_r    <= 32'h0000_0000;
         buf_valid_r <= 1'b0;
         buf_instr_r <= 32'h0000_0000;
         buf_pc_r    <= 32'h0000_0000;
         id_valid_o  <= 1'b0;
         id_instr_o  <= 32'h0000_0000;
         id_pc_o     <= 32'h0000_0000;
         id_pc4_o    <= 32'h0000_0004;
      end else if (redirect_i) begin
         fetch_pc_r  <= redirect_target_s;
         rsp_valid_r <= 1'b0;
         buf_valid_r <= 1'b0;
         id_valid_o  <= 1'b0;
      end else if (stall_i) begin
         // Park the response that arrives this cycle so it is not lost.
         if (rsp_valid_r) begin
            buf_valid_r <= 1'b1;
            buf_instr_r <= imem_rdata_i;
            buf_pc_r    <= rsp_pc_r;
         end else begin
            buf_valid_r <= buf_valid_r;
         end
         rsp_valid_r <= 1'b0;
      end else begin
         fetch_pc_r  <= fetch_pc_r + 32'd4;
         rsp_valid_r <= 1'b1;
         rsp_pc_r    <= fetch_pc_r;
         if (buf_valid_r) begin
            buf_valid_r <= 1'b0;
            id_valid_o  <= 1'b1;
            id_instr_o  <= buf_instr_r;
            id_pc_o     <= buf_pc_r;
            id_pc4_o    <= buf_pc_r + 32'd4;
         end else if (rsp_valid_r) begin
            id_valid_o  <= 1'b1;
            id_instr_o  <= imem_rdata_i;
            id_pc_o     <= rsp_pc_r;
            id_pc4_o    <= rsp_pc_r + 32'd4;
         end else begin
            id_valid_o  <= 1'b0;
         end
      end
   end

`ifdef FETCH_PERF_EN
   // Saturating counters of stalled and redirected cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_stall_cnt_o    <= 32'h0000_0000;
         perf_redirect_cnt_o <= 32'h0000_0000;
      end else begin
         if (stall_i && !redirect_i && (perf_stall_cnt_o != 32'hFFFF_FFFF)) begin
            perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
         end else begin
            perf_stall_cnt_o <= perf_stall_cnt_o;
         end
         if (redirect_i && (perf_redirect_cnt_o != 32'hFFFF_FFFF)) begin
            perf_redirect_cnt_o <= perf_redirect_cnt_o + 32'd1;
         end else begin
            perf_redirect_cnt_o <= perf_redirect_cnt_o;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Directed bench for mips_fetch_stage; imem model returns word_index+1.
module tb_mips_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        imem_en_o;
   logic [9:0]  imem_addr_o;
   logic [31:0] imem_rdata_i = 32'h0000_0000;
   logic [31:0] pc_out;
   logic        id_valid_o;
   logic [31:0] id_instr_o;
   logic [31:0] id_pc_o;
   logic [31:0] id_pc4_o;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_stall_cnt_o;
   logic [31:0] perf_redirect_cnt_o;
`endif

   int total = 0;
   int bad   = 0;

   mips_fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_AW(10)) dut (
      .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_i(redirect_i),
      .redirect_pc_i(redirect_pc_i), .imem_en_o(imem_en_o), .imem_addr_o(imem_addr_o),
      .imem_rdata_i(imem_rdata_i), .pc_out(pc_out), .id_valid_o(id_valid_o),
      .id_instr_o(id_instr_o), .id_pc_o(id_pc_o), .id_pc4_o(id_pc4_o)
`ifdef FETCH_PERF_EN
      , .perf_stall_cnt_o(perf_stall_cnt_o), .perf_redirect_cnt_o(perf_redirect_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   // Synchronous-read instruction memory: imem[i] = i + 1
   always @(posedge clk) begin
      if (imem_en_o) imem_rdata_i <= {22'd0, imem_addr_o} + 32'd1;
   end

   // Skid buffer and in-flight response must never both be valid
   always @(negedge clk) begin
      if (!rst) begin
         total++;
         assert (!(dut.buf_valid_r && dut.rsp_valid_r))
         else begin
            bad++;
            $error("FAIL invariant: observed buf_valid=%0b rsp_valid=%0b expected not both 1",
                   dut.buf_valid_r, dut.rsp_valid_r);
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_id(input string tag, input logic [31:0] pc, input logic [31:0] instr);
      check({tag, "_valid"}, {31'd0, id_valid_o}, 32'd1);
      check({tag, "_pc"}, id_pc_o, pc);
      check({tag, "_instr"}, id_instr_o, instr);
      check({tag, "_pc4"}, id_pc4_o, pc + 32'd4);
   endtask

   initial begin
      rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
      #7;
      check("rst_valid", {31'd0, id_valid_o}, 32'd0);
      check("rst_instr", id_instr_o, 32'h0);
      check("rst_pc", id_pc_o, 32'h0);
      check("rst_pc4", id_pc4_o, 32'h4);
      check("rst_pcout", pc_out, 32'h0);
      check("rst_en", {31'd0, imem_en_o}, 32'd0);
`ifdef FETCH_PERF_EN
      check("rst_perf_stall", perf_stall_cnt_o, 32'd0);
`endif
      tick(); rst = 1'b0; #1;
      check("first_en", {31'd0, imem_en_o}, 32'd1);
      check("first_addr", {22'd0, imem_addr_o}, 32'd0);
      tick();
      check("e1_valid", {31'd0, id_valid_o}, 32'd0);
      check("e1_pcout", pc_out, 32'h4);
      tick(); check_id("e2", 32'h0, 32'd1);
      tick(); check_id("e3", 32'h4, 32'd2);
      // stall while address 8 is in flight
      stall_i = 1'b1; #1;
      check("stall_en", {31'd0, imem_en_o}, 32'd0);
      tick(); check_id("stall1", 32'h4, 32'd2);
      check("stall1_pcout", pc_out, 32'hC);
      tick(); check_id("stall2", 32'h4, 32'd2);
      tick(); check_id("stall3", 32'h4, 32'd2);
      check("stall3_pcout", pc_out, 32'hC);
      stall_i = 1'b0;
      tick(); check_id("rel_buf", 32'h8, 32'd3);
      tick(); check_id("rel_next", 32'hC, 32'd4);
      tick(); check_id("rel_next2", 32'h10, 32'd5);
      // redirect to 0x40
      redirect_i = 1'b1; redirect_pc_i = 32'h40; #1;
      check("redir_en", {31'd0, imem_en_o}, 32'd0);
      tick();
      check("redir_b1", {31'd0, id_valid_o}, 32'd0);
      check("redir_pcout", pc_out, 32'h40);
      redirect_i = 1'b0;
      tick(); check("redir_b2", {31'd0, id_valid_o}, 32'd0);
      tick(); check_id("redir_t0", 32'h40, 32'd17);
      tick(); check_id("redir_t1", 32'h44, 32'd18);
      // fill the buffer, then redirect while stalled
      stall_i = 1'b1;
      tick(); check_id("fill", 32'h44, 32'd18);
      redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103;
      tick();
      check("rs_valid", {31'd0, id_valid_o}, 32'd0);
      check("rs_pcout", pc_out, 32'h100);
      redirect_i = 1'b0;
      tick();
      check("rs_hold_valid", {31'd0, id_valid_o}, 32'd0);
      check("rs_hold_pcout", pc_out, 32'h100);
      stall_i = 1'b0; #1;
      check("rs_addr", {22'd0, imem_addr_o}, 32'h40);
      tick(); check("rs_flushed", {31'd0, id_valid_o}, 32'd0);
      tick(); check_id("rs_target", 32'h100, 32'd65);
`ifdef FETCH_PERF_EN
      check("perf_stall", perf_stall_cnt_o, 32'd5);
      check("perf_redirect", perf_redirect_cnt_o, 32'd2);
`endif
      // redirect to the top of the address space and wrap
      redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
      tick();
      check("wrap_pcout", pc_out, 32'hFFFF_FFFC);
      redirect_i = 1'b0; #1;
      check("wrap_addr", {22'd0, imem_addr_o}, 32'h3FF);
      tick(); check("wrap_next", pc_out, 32'h0);
      tick(); check_id("wrap_top", 32'hFFFF_FFFC, 32'd1024);
      tick(); check_id("wrap_zero", 32'h0, 32'd1);
      // asynchronous reset in the middle of a stall
      stall_i = 1'b1;
      tick();
      #3 rst = 1'b1; #1;
      check("mid_rst_valid", {31'd0, id_valid_o}, 32'd0);
      check("mid_rst_pcout", pc_out, 32'h0);
      check("mid_rst_pc4", id_pc4_o, 32'h4);
      check("mid_rst_instr", id_instr_o, 32'h0);
`ifdef FETCH_PERF_EN
      check("perf_rst_stall", perf_stall_cnt_o, 32'd0);
      check("perf_rst_redirect", perf_redirect_cnt_o, 32'd0);
`endif
      tick(); rst = 1'b0; stall_i = 1'b0;
      tick(); check("post_rst_b", {31'd0, id_valid_o}, 32'd0);
      tick(); check_id("post_rst", 32'h0, 32'd1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mips_fetch_stage.md
Name: mips_fetch_stage

Overview:
Instruction-fetch (IF) stage of the 5-stage pipelined MIPS core. It sits directly upstream of decode.
- Owns the PC register and drives a synchronous-read instruction memory.
- Delivers instruction/PC pairs into the IF/ID pipeline register.
- Handles decode stalls without losing in-flight reads (1-entry skid buffer) and branch/jump redirects from EX.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
IMEM_AW, 10, instruction memory word-address width (1024 words)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
stall_i  input  1  decode cannot accept; hold IF/ID
redirect_i  input  1  branch/jump taken; flush and refetch
redirect_pc_i  input  32  target PC for redirect
imem_en_o  output  1  read strobe to instruction memory
imem_addr_o  output  IMEM_AW  word address = fetch_pc[IMEM_AW+1:2]
imem_rdata_i  input  32  read data, valid the cycle after the strobe
pc_out  output  32  current fetch PC (address being issued)
id_valid_o  output  1  IF/ID holds a valid instruction
id_instr_o  output  32  IF/ID instruction
id_pc_o  output  32  IF/ID PC of that instruction
id_pc4_o  output  32  id_pc_o + 4

Behaviour:
- Reset (async, active-high): fetch_pc=RESET_PC; rsp_valid=0; buf_valid=0; id_valid_o=0; id_instr_o=0; id_pc_o=0; id_pc4_o=4.
- Memory timing: address and strobe are presented in cycle N; data on imem_rdata_i is valid in cycle N+1.
- Combinational strobe: imem_en_o = !stall_i && !redirect_i. It is low during reset.
- Priority per cycle is redirect > stall > normal.
- Redirect:
  - fetch_pc <= {redirect_pc_i[31:2],2'b00}, so low bits are forced to zero.
  - rsp_valid<=0, buf_valid<=0, id_valid_o<=0. The in-flight response is discarded.
  - No issue this cycle. The target issues next cycle and reaches IF/ID two cycles after redirect, so the penalty is 2 bubbles.
- Stall (no redirect):
  - IF/ID outputs hold and no issue.
  - If rsp_valid, capture {imem_rdata_i, rsp_pc} into the skid buffer and set buf_valid=1.
  - rsp_valid<=0.
- Normal:
  - Issue fetch_pc, then fetch_pc<=fetch_pc+4 (wraps modulo 2^32), rsp_valid<=1, rsp_pc<=fetch_pc.
  - IF/ID loads from the skid buffer if buf_valid (buffer then cleared), else from the response if rsp_valid, else id_valid_o<=0.
- Invariant: buf_valid and rsp_valid are never both 1. The bench asserts this.
- Reset-to-first-instruction: first strobe is in the first cycle after rst falls. id_valid_o=1 with id_pc_o=RESET_PC at the end of the following cycle.
- Stall held for many cycles: nothing is issued and the buffer holds exactly one entry.
- Redirect during stall: the redirect wins and the buffer is flushed.
- Reset mid-stall or mid-redirect: all state clears immediately.

Optional Feature:
FETCH_PERF_EN
- Defined: adds outputs perf_stall_cnt_o[31:0] and perf_redirect_cnt_o[31:0].
  - perf_stall_cnt_o counts cycles with stall_i=1 and redirect_i=0.
  - perf_redirect_cnt_o counts cycles with redirect_i=1.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: these ports and counters do not exist.

Test Plan:
- Reset then free-run with imem[i]=i+1 -> id_pc_o sequence 0,4,8,...; id_instr_o 1,2,3,...; one instruction per cycle from the second cycle after reset.
- stall_i high 3 cycles while address 8 is in flight -> IF/ID holds PC 4; on release IF/ID shows PC 8 (from buffer), then 12; no instruction skipped or duplicated.
- redirect_i with redirect_pc_i=32'h40 -> id_valid_o low 2 cycles, then id_pc_o=32'h40, 32'h44.
- redirect_i and stall_i high together with buffer full -> buffer flushed; after stall drops, first valid id_pc_o = redirect target.
- redirect_pc_i=32'h0000_0103 -> fetch resumes at 32'h100; also redirect to 32'hFFFF_FFFC -> next fetch PC wraps to 0.
- (FETCH_PERF_EN) 5 stall cycles and 2 redirects -> perf_stall_cnt_o=5, perf_redirect_cnt_o=2; rst clears both to 0.
